// File: rtl/fifo_stream_drain_if.sv
// Valid/ready output stream of the FIFO drain.
// The drain drives the master side and the downstream consumer uses the slave side.
interface fifo_stream_drain_if #(
  parameter int FIFO_WIDTH = 16
);
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_stream_drain.sv
// Pops a synchronous FIFO into a 2-entry skid buffer and presents the words on a
// valid/ready stream, with a delivered-word counter and a sticky underflow flag.
module fifo_stream_drain #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  fifo_stream_drain_if.master   m_stream,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  underflow_err
);

  logic [1:0]            occ;
  logic [1:0]            occ_nxt;
  logic                  inflight;
  logic [FIFO_WIDTH-1:0] head;
  logic [FIFO_WIDTH-1:0] head_nxt;
  logic [FIFO_WIDTH-1:0] tail;
  logic [FIFO_WIDTH-1:0] tail_nxt;
  logic                  valid;
  logic                  pop;
  logic                  capture;
  logic [2:0]            room_sum;

  assign valid   = (occ != 2'd0);
  assign pop     = valid & m_stream.m_ready;
  assign capture = inflight & ~fifo_underflow;

  // Counting the in-flight word and the current pop keeps the buffer from ever
  // exceeding two entries while still allowing one read per cycle when draining.
  assign room_sum   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = rst_n & enable & ~fifo_empty & (room_sum < 3'd2);

  assign m_stream.m_valid = valid;
  assign m_stream.m_data  = head;

  always_comb begin
    occ_nxt  = occ;
    head_nxt = head;
    tail_nxt = tail;
    case ({capture, pop})
      2'b10: begin
        occ_nxt = occ + 2'd1;
        if (occ == 2'd0) head_nxt = fifo_data_out;
        else             tail_nxt = fifo_data_out;
      end
      2'b11: begin
        if (occ == 2'd2) begin
          head_nxt = tail;
          tail_nxt = fifo_data_out;
        end else begin
          head_nxt = fifo_data_out;
        end
      end
      2'b01: begin
        occ_nxt = occ - 2'd1;
        if (occ == 2'd2) head_nxt = tail;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ           <= 2'd0;
      inflight      <= 1'b0;
      head          <= '0;
      tail          <= '0;
      word_count    <= '0;
      underflow_err <= 1'b0;
    end else begin
      occ      <= occ_nxt;
      head     <= head_nxt;
      tail     <= tail_nxt;
      inflight <= fifo_rd_en;
      if (pop) word_count <= word_count + 1'b1;
      if (inflight && fifo_underflow) underflow_err <= 1'b1;
    end
  end

endmodule

// File: doc/fifo_stream_drain.md
Name: fifo_stream_drain

Overview:
- Downstream consumer of the synchronous FIFO.
- Pops words with rd_en whenever data is present and there is room, and absorbs the FIFO's 1-cycle read latency into a 2-entry skid buffer.
- Presents the words on a valid/ready stream, with a popped-word counter and a sticky underflow error for the bench/system.

Parameters:
- FIFO_WIDTH, 16, data word width; matches the FIFO data_out width.
- CNT_WIDTH, 16, width of the popped-word counter.

Ports:
- clk  input  1  single clock, shared with the FIFO.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  permits issuing new FIFO reads.
- fifo_empty  input  1  FIFO empty flag.
- fifo_underflow  input  1  FIFO underflow flag.
- fifo_data_out  input  FIFO_WIDTH  FIFO read data; valid the cycle after an accepted rd_en.
- fifo_rd_en  output  1  FIFO read request.
- m_data  output  FIFO_WIDTH  stream data (head of skid buffer).
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream accept.
- word_count  output  CNT_WIDTH  words delivered downstream.
- underflow_err  output  1  sticky: FIFO reported underflow on a read this block issued.

Behaviour:
- Reset values (asynchronous, immediate on rst_n low):
  - fifo_rd_en=0, m_valid=0, m_data=0, word_count=0, underflow_err=0.
  - Skid occupancy occ=0, inflight=0.
  - A word in flight at reset is discarded.
- Definitions:
  - pop = m_valid & m_ready.
  - inflight = registered fifo_rd_en from the previous cycle.
- Read issue (combinational): fifo_rd_en = enable & ~fifo_empty & ((occ + inflight - pop) < 2).
  - Including pop gives 1 word/cycle sustained throughput when m_ready is held high.
- Capture: on the cycle after fifo_rd_en=1, fifo_data_out is written into the skid buffer tail. occ_next = occ + inflight - pop.
- Overflow of the skid buffer is impossible by construction; the bench asserts occ<=2 always.
- Output:
  - m_valid = (occ!=0).
  - m_data = oldest entry.
  - Strict FIFO order is preserved.
  - m_data/m_valid are stable while m_valid=1 and m_ready=0.
- Simultaneous capture and pop:
  - With occ=1: the head is replaced by the captured word and occ stays 1.
  - With occ=2: the head shifts and the new word fills the tail.
- Same-cycle bypass (capture goes straight to m_valid) is not allowed. A captured word appears on m_valid the cycle after capture (2-cycle latency from fifo_rd_en to m_valid).
- enable deasserted:
  - No new reads are issued.
  - An in-flight word is still captured.
  - Buffered words still drain downstream.
- fifo_empty high: fifo_rd_en=0 regardless of space.
- word_count increments by 1 on every pop and wraps from 2^CNT_WIDTH-1 to 0.
- underflow_err sets if fifo_underflow=1 in the cycle fifo_rd_en=1 (the FIFO's registered underflow response, sampled one cycle later). It clears only on reset.
  - That cycle's capture is still suppressed: the inflight bit is qualified with ~fifo_underflow.
- No combinational path from fifo_data_out to any output. A combinational path exists from m_ready and fifo_empty to fifo_rd_en.

Test Plan:
1. Reset then streaming:
   - Stimulus: load 8 words 0x0001..0x0008 into the FIFO; enable=1; m_ready=1.
   - Response: m_valid high 2 cycles after the first rd_en, then 8 consecutive beats 0x0001..0x0008; word_count=8; fifo_rd_en never high while fifo_empty=1.
2. Backpressure:
   - Stimulus: FIFO holds 5 words, m_ready=0.
   - Response: exactly 2 rd_en pulses; occ=2; m_data=first word held stable.
   - Stimulus: then m_ready=1.
   - Response: remaining 3 read, all 5 delivered in order.
3. Alternating m_ready (1,0,1,0...) with 8 words:
   - Response: no loss or duplication; order preserved; occ never >2.
4. Enable drop mid-stream:
   - Stimulus: deassert enable the cycle rd_en is high.
   - Response: that in-flight word is still delivered; no further rd_en until enable=1.
5. Forced underflow:
   - Stimulus: bench drives fifo_underflow=1 the cycle after an issued rd_en.
   - Response: underflow_err=1 and stays 1; no word captured.
6. Reset mid-operation and counter wrap:
   - Stimulus: rst_n low while occ=2 and inflight=1.
   - Response: all outputs go to reset values immediately.
   - Separately: with CNT_WIDTH=4, 17 pops -> word_count=1.
